fm_spy_chan: RTL and testbench

- Parametrised multi-channel spy buffer for fast monitoring. It generalises the per-SB freeze/playback scheme to N_CH independent channels of configurable width and depth.
- Each channel continuously captures valid samples into a circular buffer. On a freeze request it captures a programmable number of post-trigger samples, then freezes.
- Frozen contents are readable by random access and can be replayed onto a playback port in single-shot or loop mode.
- Sits between the ULT monitor data taps and the FM readout/control logic, in the clk_hs domain.

---
 rtl/fm_spy_chan.sv | 197 +++++++++++++++++++
 tb/tb_fm_spy_chan.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_spy_chan.sv
// Multi-channel spy buffer: circular capture per channel, freeze after a post-trigger count,
// random-access readout and single-shot/loop playback sharing one read port per channel.
module fm_spy_chan #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned DEPTH_LOG2 = 6,
    parameter int unsigned PB_MODE_W  = 2,
    localparam int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                            clk_hs,
    input  logic                            rst_hs,
    input  logic [N_CH*DATA_W-1:0]          in_data,
    input  logic [N_CH-1:0]                 in_valid,
    input  logic [N_CH-1:0]                 freeze_req,
    input  logic [N_CH-1:0]                 unfreeze,
    input  logic [DEPTH_LOG2-1:0]           post_cnt,
    input  logic [N_CH*PB_MODE_W-1:0]       pb_mode,
    input  logic                            rd_en,
    input  logic [CH_W-1:0]                 rd_ch,
    input  logic [DEPTH_LOG2-1:0]           rd_addr,
    output logic [DATA_W-1:0]               rd_data,
    output logic                            rd_valid,
    output logic [N_CH-1:0]                 frozen,
    output logic [N_CH*(DEPTH_LOG2+1)-1:0]  fill,
    output logic [N_CH*DATA_W-1:0]          pb_data,
    output logic [N_CH-1:0]                 pb_valid
);

    localparam int unsigned D  = 2 ** DEPTH_LOG2;
    localparam int unsigned FW = DEPTH_LOG2 + 1;
    localparam logic [FW-1:0] FillMax = FW'(D);

    typedef enum logic [1:0] {StArmed, StPost, StFrozen, StPlayback} state_e;

    // Random-read pipeline: stage 1 owns the channel RAM port, stage 2 presents the result.
    logic                   r_rd_v1;
    logic [CH_W-1:0]        r_rd_ch1;
    logic [DEPTH_LOG2-1:0]  r_rd_addr1;
    logic                   r_rd_valid;
    logic                   r_rd_zero;
    logic [CH_W-1:0]        r_rd_ch2;
    logic [N_CH*DATA_W-1:0] w_q;
    logic [31:0]            w_rd_ch_ext;
    logic [FW-1:0]          w_rd_fill;
    logic                   w_rd_zero;

    assign w_rd_ch_ext = 32'(r_rd_ch1);

    always_comb begin
        w_rd_fill = '0;
        w_rd_zero = 1'b1;
        if (w_rd_ch_ext < N_CH) begin
            w_rd_fill = fill[r_rd_ch1*FW +: FW];
            w_rd_zero = !frozen[r_rd_ch1] || ({1'b0, r_rd_addr1} >= w_rd_fill);
        end
    end

    always_ff @(posedge clk_hs) begin
        if (rst_hs) begin
            r_rd_v1    <= 1'b0;
            r_rd_ch1   <= '0;
            r_rd_addr1 <= '0;
            r_rd_valid <= 1'b0;
            r_rd_zero  <= 1'b0;
            r_rd_ch2   <= '0;
        end else begin
            r_rd_v1    <= rd_en;
            r_rd_ch1   <= rd_ch;
            r_rd_addr1 <= rd_addr;
            r_rd_valid <= r_rd_v1;
            r_rd_zero  <= w_rd_zero;
            r_rd_ch2   <= r_rd_ch1;
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = (r_rd_valid && !r_rd_zero) ? w_q[r_rd_ch2*DATA_W +: DATA_W] : '0;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        state_e                r_state;
        logic [DEPTH_LOG2-1:0] r_wr_ptr;
        logic [DEPTH_LOG2-1:0] r_post;
        logic [DEPTH_LOG2-1:0] r_pb_idx;
        logic [FW-1:0]         r_fill;
        logic                  r_pb_done;
        logic                  r_pb_loop;
        logic                  r_pb_valid;
        logic [DATA_W-1:0]     r_q;
        logic [DATA_W-1:0]     r_mem [D];

        logic [PB_MODE_W-1:0]  w_mode;
        logic                  w_mode_on;
        logic                  w_rd_hit;
        logic                  w_we;
        logic                  w_pb_last;
        logic [DEPTH_LOG2-1:0] w_oldest;
        logic [DEPTH_LOG2-1:0] w_rd_idx;
        logic [DEPTH_LOG2-1:0] w_pb_rd_idx;

        assign w_mode      = pb_mode[c*PB_MODE_W +: PB_MODE_W];
        assign w_mode_on   = (w_mode == PB_MODE_W'(1)) || (w_mode == PB_MODE_W'(2));
        // A full buffer has fill low bits of zero, so oldest collapses to wr_ptr.
        assign w_oldest    = r_wr_ptr - r_fill[DEPTH_LOG2-1:0];
        assign w_rd_idx    = w_oldest + r_rd_addr1;
        assign w_pb_rd_idx = w_oldest + r_pb_idx;
        assign w_rd_hit    = r_rd_v1 && (r_rd_ch1 == CH_W'(c));
        assign w_we        = !rst_hs && in_valid[c] && (r_state == StArmed || r_state == StPost);
        assign w_pb_last   = ({1'b0, r_pb_idx} == (r_fill - 1'b1));

        always_ff @(posedge clk_hs) begin
            if (w_we) begin
                r_mem[r_wr_ptr] <= in_data[c*DATA_W +: DATA_W];
            end
        end

        always_ff @(posedge clk_hs) begin
            if (rst_hs) begin
                r_state    <= StArmed;
                r_wr_ptr   <= '0;
                r_post     <= '0;
                r_pb_idx   <= '0;
                r_fill     <= '0;
                r_pb_done  <= 1'b0;
                r_pb_loop  <= 1'b0;
                r_pb_valid <= 1'b0;
                r_q        <= '0;
            end else begin
                r_pb_valid <= 1'b0;
                if (w_rd_hit) begin
                    r_q <= r_mem[w_rd_idx];
                end
                unique case (r_state)
                    StArmed: begin
                        if (in_valid[c]) begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                            if (r_fill != FillMax) r_fill <= r_fill + 1'b1;
                        end
                        if (freeze_req[c]) begin
                            r_post  <= post_cnt;
                            r_state <= (post_cnt == '0) ? StFrozen : StPost;
                        end
                    end
                    StPost: begin
                        if (in_valid[c]) begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                            if (r_fill != FillMax) r_fill <= r_fill + 1'b1;
                            r_post <= r_post - 1'b1;
                            if (r_post == DEPTH_LOG2'(1)) r_state <= StFrozen;
                        end
                    end
                    StFrozen: begin
                        if (unfreeze[c]) begin
                            r_state   <= StArmed;
                            r_fill    <= '0;
                            r_pb_done <= 1'b0;
                        end else if (w_mode_on && r_fill != '0 && !r_pb_done) begin
                            r_state   <= StPlayback;
                            r_pb_loop <= (w_mode == PB_MODE_W'(2));
                            r_pb_idx  <= '0;
                            r_pb_done <= 1'b0;
                        end else if (!w_mode_on) begin
                            r_pb_done <= 1'b0;
                        end
                    end
                    StPlayback: begin
                        if (unfreeze[c]) begin
                            r_state   <= StArmed;
                            r_fill    <= '0;
                            r_pb_done <= 1'b0;
                        end else if (!w_rd_hit) begin
                            // Random read owns the port this cycle; playback just holds.
                            r_q        <= r_mem[w_pb_rd_idx];
                            r_pb_valid <= 1'b1;
                            if (w_pb_last) begin
                                r_pb_idx <= '0;
                                if (!r_pb_loop) begin
                                    r_state   <= StFrozen;
                                    r_pb_done <= 1'b1;
                                end
                            end else begin
                                r_pb_idx <= r_pb_idx + 1'b1;
                            end
                        end
                    end
                    default: r_state <= StArmed;
                endcase
            end
        end

        assign frozen[c]                  = (r_state == StFrozen) || (r_state == StPlayback);
        assign fill[c*FW +: FW]           = r_fill;
        assign pb_valid[c]                = r_pb_valid;
        assign pb_data[c*DATA_W +: DATA_W] = r_pb_valid ? r_q : '0;
        assign w_q[c*DATA_W +: DATA_W]    = r_q;
    end

endmodule

// File: tb/tb_fm_spy_chan.sv
// Directed bench for fm_spy_chan: table-driven random reads plus hand-written playback,
// unfreeze and reset sequences.
module tb_fm_spy_chan;

    localparam int N_CH   = 4;
    localparam int DATA_W = 64;
    localparam int DL     = 6;
    localparam int PMW    = 2;
    localparam int FW     = DL + 1;

    logic                     clk_hs = 1'b0;
    logic                     rst_hs;
    logic [N_CH*DATA_W-1:0]   in_data;
    logic [N_CH-1:0]          in_valid;
    logic [N_CH-1:0]          freeze_req;
    logic [N_CH-1:0]          unfreeze;
    logic [DL-1:0]            post_cnt;
    logic [N_CH*PMW-1:0]      pb_mode;
    logic                     rd_en;
    logic [1:0]               rd_ch;
    logic [DL-1:0]            rd_addr;
    logic [DATA_W-1:0]        rd_data;
    logic                     rd_valid;
    logic [N_CH-1:0]          frozen;
    logic [N_CH*FW-1:0]       fill;
    logic [N_CH*DATA_W-1:0]   pb_data;
    logic [N_CH-1:0]          pb_valid;

    fm_spy_chan #(
        .N_CH(N_CH), .DATA_W(DATA_W), .DEPTH_LOG2(DL), .PB_MODE_W(PMW)
    ) dut (
        .clk_hs(clk_hs), .rst_hs(rst_hs), .in_data(in_data), .in_valid(in_valid),
        .freeze_req(freeze_req), .unfreeze(unfreeze), .post_cnt(post_cnt), .pb_mode(pb_mode),
        .rd_en(rd_en), .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .frozen(frozen), .fill(fill), .pb_data(pb_data),
        .pb_valid(pb_valid)
    );

    always #5 clk_hs = ~clk_hs;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int          ch;
        int          addr;
        logic [63:0] exp;
    } rd_vec_t;

    rd_vec_t     tbl[$];
    logic [63:0] abc[3];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_hs);
        #1;
    endtask

    function automatic logic [63:0] mk(input int c, input int s);
        return {8'(c), 56'(s)};
    endfunction

    function automatic logic [63:0] fill_of(input int c);
        return 64'(fill[c*FW +: FW]);
    endfunction

    function automatic logic [63:0] pbd(input int c);
        return pb_data[c*DATA_W +: DATA_W];
    endfunction

    task automatic push(input int c, input logic [63:0] v, input logic frz);
        in_data[c*DATA_W +: DATA_W] = v;
        in_valid[c]   = 1'b1;
        freeze_req[c] = frz;
        tick();
        in_valid[c]   = 1'b0;
        freeze_req[c] = 1'b0;
    endtask

    task automatic set_mode(input int c, input int m);
        pb_mode[c*PMW +: PMW] = PMW'(m);
    endtask

    initial begin
        int idx, nvalid, ngap, nrd;
        logic [63:0] z;
        z = '0;
        rst_hs = 1'b1; in_data = '0; in_valid = '0; freeze_req = '0; unfreeze = '0;
        post_cnt = '0; pb_mode = '0; rd_en = 1'b0; rd_ch = '0; rd_addr = '0;
        tick(); tick();
        rst_hs = 1'b0;
        check("rst_frozen", 64'(frozen), z);
        check("rst_fill", 64'(fill), z);
        check("rst_rd_valid", 64'(rd_valid), z);
        check("rst_rd_data", rd_data, z);
        check("rst_pb_valid", 64'(pb_valid), z);

        // Ch0: 10 samples, freeze with no post-trigger samples
        for (int s = 0; s < 10; s++) push(0, mk(0, s), 1'b0);
        check("ch0_fill_armed", fill_of(0), 64'd10);
        check("ch0_armed", 64'(frozen[0]), 64'd0);
        post_cnt = '0;
        freeze_req[0] = 1'b1; tick(); freeze_req[0] = 1'b0;
        check("ch0_frozen", 64'(frozen[0]), 64'd1);
        check("ch0_fill", fill_of(0), 64'd10);

        // Ch3: wrap with 100 samples, trigger on 94 with 5 post samples
        post_cnt = 6'd5;
        for (int s = 0; s < 100; s++) begin
            push(3, mk(3, s), (s == 94));
            if (s == 98) check("ch3_post_not_frozen", 64'(frozen[3]), 64'd0);
        end
        check("ch3_frozen", 64'(frozen[3]), 64'd1);
        check("ch3_fill_sat", fill_of(3), 64'd64);
        push(3, mk(3, 200), 1'b1);
        check("ch3_fill_ignore", fill_of(3), 64'd64);

        for (int a = 0; a < 11; a++) tbl.push_back('{0, a, (a < 10) ? mk(0, a) : 64'd0});
        tbl.push_back('{3, 0, mk(3, 36)});
        tbl.push_back('{3, 63, mk(3, 99)});
        tbl.push_back('{3, 10, mk(3, 46)});
        tbl.push_back('{1, 0, 64'd0});
        foreach (tbl[i]) begin
            rd_en = 1'b1; rd_ch = 2'(tbl[i].ch); rd_addr = DL'(tbl[i].addr);
            tick();
            rd_en = 1'b0;
            tick();
            check($sformatf("rd_valid_%0d", i), 64'(rd_valid), 64'd1);
            check($sformatf("rd_data_c%0d_a%0d", tbl[i].ch, tbl[i].addr), rd_data, tbl[i].exp);
        end

        // Back-to-back reads: one result per cycle, two cycles after issue
        for (int i = 0; i < 6; i++) begin
            rd_en = 1'b1; rd_ch = 2'd0; rd_addr = DL'(i);
            tick();
            if (i >= 1) check($sformatf("pipe_rd_%0d", i - 1), rd_data, mk(0, i - 1));
        end
        rd_en = 1'b0;
        tick();
        check("pipe_rd_5", rd_data, mk(0, 5));
        tick();
        check("pipe_rd_idle", 64'(rd_valid), 64'd0);

        // Ch2: playback once of A,B,C
        abc[0] = mk(2, 'hA); abc[1] = mk(2, 'hB); abc[2] = mk(2, 'hC);
        post_cnt = '0;
        push(2, abc[0], 1'b0); push(2, abc[1], 1'b0); push(2, abc[2], 1'b1);
        check("ch2_frozen", 64'(frozen[2]), 64'd1);
        check("ch2_fill", fill_of(2), 64'd3);
        set_mode(2, 1);
        tick();
        check("once_first_gap", 64'(pb_valid[2]), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("once_valid_%0d", i), 64'(pb_valid[2]), 64'd1);
            check($sformatf("once_data_%0d", i), pbd(2), abc[i]);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("once_no_restart_%0d", i), 64'(pb_valid[2]), 64'd0);
        end
        check("once_back_frozen", 64'(frozen[2]), 64'd1);
        set_mode(2, 0); tick();
        set_mode(2, 1); tick();
        tick();
        check("once_restart_data", pbd(2), abc[0]);
        check("once_restart_valid", 64'(pb_valid[2]), 64'd1);
        tick(); tick(); tick();
        set_mode(2, 0); tick();

        // Loop playback with one colliding random read on the same channel
        set_mode(2, 2); tick();
        idx = 0; nvalid = 0; ngap = 0; nrd = 0;
        for (int i = 0; i < 14; i++) begin
            rd_en = (i == 4); rd_ch = 2'd2; rd_addr = 6'd1;
            tick();
            if (pb_valid[2]) begin
                check($sformatf("loop_data_%0d", i), pbd(2), abc[idx]);
                idx = (idx + 1) % 3;
                nvalid++;
            end else begin
                ngap++;
            end
            if (rd_valid) begin
                nrd++;
                check("loop_rd_data", rd_data, abc[1]);
            end
        end
        rd_en = 1'b0;
        check("loop_gaps", 64'(ngap), 64'd1);
        check("loop_rd_count", 64'(nrd), 64'd1);
        check("loop_valid_count", 64'(nvalid), 64'd13);
        unfreeze[2] = 1'b1; set_mode(2, 0); tick(); unfreeze[2] = 1'b0;
        check("unfrz_pb_valid", 64'(pb_valid[2]), 64'd0);
        check("unfrz_frozen", 64'(frozen[2]), 64'd0);
        check("unfrz_fill", fill_of(2), 64'd0);

        // Ch1: unfreeze beats freeze_req; write pointer is kept
        for (int s = 0; s < 5; s++) push(1, mk(1, s), 1'b0);
        freeze_req[1] = 1'b1; tick();
        check("ch1_frozen", 64'(frozen[1]), 64'd1);
        unfreeze[1] = 1'b1; tick();
        unfreeze[1] = 1'b0; freeze_req[1] = 1'b0;
        check("ch1_unfrz_armed", 64'(frozen[1]), 64'd0);
        check("ch1_unfrz_fill", fill_of(1), 64'd0);
        check("ch0_unaffected", 64'(frozen[0]), 64'd1);
        check("ch0_fill_kept", fill_of(0), 64'd10);
        post_cnt = 6'd2;
        push(1, mk(1, 10), 1'b1);
        check("ch1_post", 64'(frozen[1]), 64'd0);
        push(1, mk(1, 11), 1'b0);
        check("ch1_post2", 64'(frozen[1]), 64'd0);
        push(1, mk(1, 12), 1'b0);
        check("ch1_refrozen", 64'(frozen[1]), 64'd1);
        check("ch1_fill3", fill_of(1), 64'd3);
        for (int a = 0; a < 4; a++) begin
            rd_en = 1'b1; rd_ch = 2'd1; rd_addr = DL'(a);
            tick(); rd_en = 1'b0; tick();
            check($sformatf("ch1_rd_%0d", a), rd_data, (a < 3) ? mk(1, 10 + a) : 64'd0);
        end

        // Reset during playback with a read in flight
        set_mode(0, 2); tick(); tick();
        check("rst_pre_pb_valid", 64'(pb_valid[0]), 64'd1);
        rd_en = 1'b1; rd_ch = 2'd0; rd_addr = 6'd3; tick();
        rd_en = 1'b0; rst_hs = 1'b1; tick();
        check("midrst_frozen", 64'(frozen), z);
        check("midrst_fill", 64'(fill), z);
        check("midrst_pb_valid", 64'(pb_valid), z);
        check("midrst_pb_data0", pbd(0), z);
        check("midrst_rd_valid", 64'(rd_valid), z);
        check("midrst_rd_data", rd_data, z);
        rst_hs = 1'b0; set_mode(0, 0); tick();
        check("postrst_no_rd_valid", 64'(rd_valid), z);
        check("postrst_armed", 64'(frozen), z);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
